// File: rtl/batchnorm_pipe.sv
// batchnorm_pipe: per-channel y = sat((x - mean) * inv_std + beta), Q-format fixed point.
// Three-stage pipeline with a global stall; coefficients travel with each sample.
module batchnorm_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int CH_NUM = 16,
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_coef_we,
    input  logic [CH_W-1:0]   i_coef_addr,
    input  logic [DATA_W-1:0] i_coef_mean,
    input  logic [DATA_W-1:0] i_coef_inv_std,
    input  logic [DATA_W-1:0] i_coef_beta,
    input  logic              i_bypass,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CH_W-1:0]   i_ch,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_sat,
    input  logic              i_ready,
    input  logic              i_clr_ovf,
    output logic              o_overflow
);

    localparam int PW = 2 * DATA_W + 1;
    localparam int SW = PW + 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_NUM);
    localparam logic signed [DATA_W-1:0] INV_ONE = DATA_W'(1) << FRAC_W;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) << (DATA_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = -(SW'(1) << (DATA_W - 1));

    logic signed [DATA_W-1:0] mean_tbl [CH_NUM];
    logic signed [DATA_W-1:0] inv_tbl  [CH_NUM];
    logic signed [DATA_W-1:0] beta_tbl [CH_NUM];

    logic              accept;
    logic              wr_ok;
    logic [CH_W-1:0]   rd_idx;
    logic signed [DATA_W-1:0] rd_mean;

    logic                     s1_v;
    logic [CH_W-1:0]          s1_ch;
    logic                     s1_byp;
    logic [DATA_W-1:0]        s1_x;
    logic signed [DATA_W:0]   s1_diff;
    logic signed [DATA_W-1:0] s1_inv;
    logic signed [DATA_W-1:0] s1_beta;

    logic                     s2_v;
    logic [CH_W-1:0]          s2_ch;
    logic                     s2_byp;
    logic [DATA_W-1:0]        s2_x;
    logic signed [PW-1:0]     s2_prod;
    logic signed [DATA_W-1:0] s2_beta;

    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] shf;
    logic signed [SW-1:0] sum;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [DATA_W-1:0]    sat_data;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign wr_ok   = i_coef_we && ({1'b0, i_coef_addr} < CH_LIM);
    assign rd_idx  = ({1'b0, i_ch} < CH_LIM) ? i_ch : '0;
    assign rd_mean = mean_tbl[rd_idx];

    // Table writes land at the edge, so a same-cycle accept reads old values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                mean_tbl[i] <= '0;
                inv_tbl[i]  <= INV_ONE;
                beta_tbl[i] <= '0;
            end
        end else if (wr_ok) begin
            mean_tbl[i_coef_addr] <= i_coef_mean;
            inv_tbl[i_coef_addr]  <= i_coef_inv_std;
            beta_tbl[i_coef_addr] <= i_coef_beta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (o_ready) begin
            s1_v    <= accept;
            s1_ch   <= rd_idx;
            s1_byp  <= i_bypass;
            s1_x    <= i_data;
            s1_diff <= {i_data[DATA_W-1], i_data}
                     - {rd_mean[DATA_W-1], rd_mean};
            s1_inv  <= inv_tbl[rd_idx];
            s1_beta <= beta_tbl[rd_idx];

            s2_v    <= s1_v;
            s2_ch   <= s1_ch;
            s2_byp  <= s1_byp;
            s2_x    <= s1_x;
            s2_prod <= PW'(s1_diff) * PW'(s1_inv);
            s2_beta <= s1_beta;
        end
    end

    // Round half-up, rescale, add bias; only the final sum is clamped.
    always_comb begin
        rnd      = s2_prod + HALF;
        shf      = rnd >>> FRAC_W;
        sum      = SW'(shf) + SW'(s2_beta);
        sat_hi   = sum > MAXV;
        sat_lo   = sum < MINV;
        sat_data = sum[DATA_W-1:0];
        if (sat_hi) begin
            sat_data = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (sat_lo) begin
            sat_data = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            o_sat   <= 1'b0;
        end else if (o_ready) begin
            o_valid <= s2_v;
            o_ch    <= s2_ch;
            o_data  <= s2_byp ? s2_x : sat_data;
            o_sat   <= !s2_byp && (sat_hi || sat_lo);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (o_valid && i_ready && o_sat) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_batchnorm_pipe.sv
// tb_batchnorm_pipe: directed vectors, queue scoreboard, negedge monitor.
// Values are Q16.16; expected results are computed by hand.
module tb_batchnorm_pipe;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_coef_we = 1'b0;
    logic [CW-1:0] i_coef_addr = '0;
    logic [DW-1:0] i_coef_mean = '0;
    logic [DW-1:0] i_coef_inv_std = '0;
    logic [DW-1:0] i_coef_beta = '0;
    logic          i_bypass = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [CW-1:0] i_ch = '0;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_ch;
    logic          o_sat;
    logic          i_ready = 1'b1;
    logic          i_clr_ovf = 1'b0;
    logic          o_overflow;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] ch;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    batchnorm_pipe #(.DATA_W(32), .FRAC_W(16), .CH_NUM(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_mean(i_coef_mean), .i_coef_inv_std(i_coef_inv_std),
        .i_coef_beta(i_coef_beta), .i_bypass(i_bypass),
        .i_valid(i_valid), .i_data(i_data), .i_ch(i_ch),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .o_ch(o_ch), .o_sat(o_sat), .i_ready(i_ready),
        .i_clr_ovf(i_clr_ovf), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops on every transfer, and checks outputs hold during stalls.
    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b0;
    logic [DW-1:0] prev_d;
    logic [CW-1:0] prev_ch;
    logic          prev_sat;
    exp_t          e;

    always @(negedge clk) begin
        if (rst_n && prev_rst && prev_stall) begin
            checks++;
            if (!o_valid || o_data !== prev_d || o_ch !== prev_ch
                || o_sat !== prev_sat) begin
                failures++;
                $display("FAIL stall_hold: got v=%b d=%h ch=%0d sat=%b want d=%h ch=%0d sat=%b",
                         o_valid, o_data, o_ch, o_sat, prev_d, prev_ch, prev_sat);
            end
        end
        if (rst_n && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got d=%h ch=%0d want nothing",
                         o_data, o_ch);
            end else begin
                e = sb.pop_front();
                if (o_data !== e.d || o_ch !== e.ch || o_sat !== e.sat) begin
                    failures++;
                    $display("FAIL result: got d=%h ch=%0d sat=%b want d=%h ch=%0d sat=%b",
                             o_data, o_ch, o_sat, e.d, e.ch, e.sat);
                end
            end
        end
        prev_stall = rst_n && o_valid && !i_ready;
        prev_d     = o_data;
        prev_ch    = o_ch;
        prev_sat   = o_sat;
        prev_rst   = rst_n;
    end

    task automatic wr(input logic [CW-1:0] a, input logic [DW-1:0] m,
                      input logic [DW-1:0] s, input logic [DW-1:0] b);
        i_coef_we = 1'b1;
        i_coef_addr = a;
        i_coef_mean = m;
        i_coef_inv_std = s;
        i_coef_beta = b;
        @(posedge clk);
        #1;
        i_coef_we = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [CW-1:0] ch,
                        input logic byp, input logic [DW-1:0] ed,
                        input logic es, input bit push);
        bit done;
        done = 1'b0;
        i_valid = 1'b1;
        i_data = x;
        i_ch = ch;
        i_bypass = byp;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (o_ready) begin
                done = 1'b1;
                if (push) sb.push_back('{ed, ch, es});
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_bypass = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept want accept on ch %0d", ch);
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (o_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: got o_valid=0 want 1");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ch", 32'(o_ch), 32'd0);
        chk("rst_sat", 32'(o_sat), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);

        // ch3: mean 2.0, inv_std 0.5, beta 1.0 -> y = x / 2
        wr(4'd3, 32'h0002_0000, 32'h0000_8000, 32'h0001_0000);
        send(32'h0006_0000, 4'd3, 1'b0, 32'h0003_0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("lat_n2", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n3", 32'(o_valid), 32'd1);
        drain();

        // x = 1 LSB: exact result is 0.5 LSB, rounds half-up to 1
        send(32'h0000_0001, 4'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 4'd3, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        drain();

        // Positive saturation, then clear
        wr(4'd0, 32'h8300_0000, 32'h0004_0000, 32'h0);
        send(32'h7D00_0000, 4'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_valid();
        chk("ovf_before", 32'(o_overflow), 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_set", 32'(o_overflow), 32'd1);
        i_clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        i_clr_ovf = 1'b0;
        chk("ovf_clr", 32'(o_overflow), 32'd0);
        drain();

        // Negative saturation with clear held: set wins
        wr(4'd2, 32'h7D00_0000, 32'h0004_0000, 32'h0);
        i_clr_ovf = 1'b1;
        send(32'h8300_0000, 4'd2, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        wait_valid();
        @(posedge clk);
        #1;
        chk("ovf_set_wins", 32'(o_overflow), 32'd1);
        i_clr_ovf = 1'b0;
        drain();

        // Write ch1 (inv_std 2.0) in the same cycle as a ch1 accept
        i_coef_we = 1'b1;
        i_coef_addr = 4'd1;
        i_coef_mean = 32'h0;
        i_coef_inv_std = 32'h0002_0000;
        i_coef_beta = 32'h0;
        send(32'h0001_8000, 4'd1, 1'b0, 32'h0001_8000, 1'b0, 1'b1);
        i_coef_we = 1'b0;
        send(32'h0001_8000, 4'd1, 1'b0, 32'h0003_0000, 1'b0, 1'b1);
        drain();

        // Back-to-back stream on ch3 with i_ready pattern 1,0,0,...
        fork
            begin
                for (int k = 1; k <= 10; k++)
                    send(32'(k) << 17, 4'd3, 1'b0, 32'(k) << 16, 1'b0, 1'b1);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1;
                    i_ready = (c % 3 == 0);
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset discards everything in flight
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(32'h0001_0000, 4'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_data", o_data, 32'd0);
        chk("midrst_ovf", 32'(o_overflow), 32'd0);
        i_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(32'h0007_4000, 4'd5, 1'b0, 32'h0007_4000, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
